// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: FSM encoding, oversampling ratio and frame defaults.
// Also intended for the uart_rx and baud generator siblings.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int DEF_NB_DATA = 8;
  localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter draining a first-word-fall-through TX FIFO.
// Bit timing comes from an external 16x baud tick; all outputs are registered.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int NB_DATA     = DEF_NB_DATA,
  parameter int SB_TICK     = DEF_SB_TICK,
  parameter int NB_TICK_CNT = 5
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_fifo_empty,
  input  logic [NB_DATA-1:0] i_fifo_rdata,
  output logic               o_fifo_rd,
  output logic               o_tx,
  output logic               o_tx_busy,
  output logic               o_tx_done
);

  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [BW-1:0]          LAST_BIT = BW'(NB_DATA - 1);
  localparam logic [NB_TICK_CNT-1:0] BIT_END  = NB_TICK_CNT'(OVERSAMPLE - 1);
  localparam logic [NB_TICK_CNT-1:0] STOP_END = NB_TICK_CNT'(SB_TICK - 1);

  uart_state_e          state, state_nxt;
  logic [NB_TICK_CNT-1:0] tick_cnt, tick_cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [NB_DATA-1:0]   shreg, shreg_nxt;
  logic                 tx_nxt, rd_nxt, done_nxt, busy_nxt;
  logic                 bit_end, stop_end;

  assign bit_end  = (tick_cnt == BIT_END);
  assign stop_end = (tick_cnt == STOP_END);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (!i_fifo_empty)                            state_nxt = ST_START;
      ST_START: if (i_tick && bit_end)                        state_nxt = ST_DATA;
      ST_DATA:  if (i_tick && bit_end && bit_cnt == LAST_BIT) state_nxt = ST_STOP;
      ST_STOP:  if (i_tick && stop_end)                       state_nxt = ST_IDLE;
      default:                                                state_nxt = ST_IDLE;
    endcase
  end

  // Counters only move on ticks and are always returned to zero explicitly.
  always_comb begin
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    unique case (state)
      ST_IDLE: begin
        tick_cnt_nxt = '0;
        if (!i_fifo_empty) shreg_nxt = i_fifo_rdata;
      end
      ST_START: if (i_tick) begin
        if (bit_end) begin
          tick_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
        end else tick_cnt_nxt = tick_cnt + 1'b1;
      end
      ST_DATA: if (i_tick) begin
        if (bit_end) begin
          tick_cnt_nxt = '0;
          bit_cnt_nxt  = bit_cnt + 1'b1;
          shreg_nxt    = shreg >> 1;
        end else tick_cnt_nxt = tick_cnt + 1'b1;
      end
      ST_STOP: if (i_tick) tick_cnt_nxt = stop_end ? '0 : tick_cnt + 1'b1;
      default: ;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered line
  // changes on the same edge as the FSM.
  always_comb begin
    tx_nxt = 1'b1;
    unique case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = shreg_nxt[0];
      default:  tx_nxt = 1'b1;
    endcase
    rd_nxt   = (state == ST_IDLE) && !i_fifo_empty;
    done_nxt = (state == ST_STOP) && i_tick && stop_end;
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      o_tx      <= 1'b1;
      o_fifo_rd <= 1'b0;
      o_tx_done <= 1'b0;
      o_tx_busy <= 1'b0;
    end else begin
      tick_cnt  <= tick_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      o_tx      <= tx_nxt;
      o_fifo_rd <= rd_nxt;
      o_tx_done <= done_nxt;
      o_tx_busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: FIFO model, line-level frame decoder, table vectors,
// corner-case sequences and randomized bursts; second instance has a 2-bit stop.
module tb_uart_tx_fifo;
  localparam int NB          = 8;
  localparam int SB          = 16;
  localparam int FRAME_TICKS = 16 * (NB + 1) + SB;

  logic          clk = 1'b0;
  logic          i_rst, i_tick, i_fifo_empty;
  logic [NB-1:0] i_fifo_rdata;
  logic          o_fifo_rd, o_tx, o_tx_busy, o_tx_done;
  logic          empty32;
  logic [NB-1:0] rdata32;
  logic          rd32, tx32, busy32, done32;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.NB_DATA(NB), .SB_TICK(SB), .NB_TICK_CNT(5)) dut (
    .clk(clk), .i_rst(i_rst), .i_tick(i_tick), .i_fifo_empty(i_fifo_empty),
    .i_fifo_rdata(i_fifo_rdata), .o_fifo_rd(o_fifo_rd), .o_tx(o_tx),
    .o_tx_busy(o_tx_busy), .o_tx_done(o_tx_done));

  uart_tx_fifo #(.NB_DATA(NB), .SB_TICK(32), .NB_TICK_CNT(6)) dut32 (
    .clk(clk), .i_rst(i_rst), .i_tick(i_tick), .i_fifo_empty(empty32),
    .i_fifo_rdata(rdata32), .o_fifo_rd(rd32), .o_tx(tx32),
    .o_tx_busy(busy32), .o_tx_done(done32));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Baud tick source: one pulse every tick_div cycles while enabled.
  bit tick_en  = 1'b1;
  int tick_div = 3;
  int tick_ph  = 0;
  always @(negedge clk) begin
    tick_ph = tick_ph + 1;
    if (tick_ph >= tick_div) tick_ph = 0;
    i_tick = tick_en && (tick_ph == 0);
  end

  // FWFT FIFO model plus the queue of bytes the line must carry, in order.
  logic [NB-1:0] fifo_q[$];
  logic [NB-1:0] exp_q[$];
  int pops = 0;
  int rd_empty_viol = 0;

  task automatic fifo_refresh();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [NB-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    fifo_refresh();
  endtask

  always @(negedge clk) begin
    if (o_fifo_rd === 1'b1 && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
      fifo_refresh();
    end
  end

  // Line decoder: every tick edge inside a frame checks the level held before it
  // against the ideal 8N1 waveform for the expected byte.
  bit            mon_active = 1'b0;
  int            mon_k = 0, mon_bad = 0, mon_slot = 0;
  logic          mon_prev = 1'b1, mon_eb;
  logic [NB-1:0] mon_exp;
  logic [9:0]    mon_slots, last_slots;
  logic [NB-1:0] last_byte;
  int            frames = 0, done_cnt = 0, stray_done = 0, gap_ticks = 0;
  int            gap_q[$];

  always @(posedge clk) begin
    #1;
    if (o_fifo_rd === 1'b1 && i_fifo_empty === 1'b1) rd_empty_viol++;
    if (o_tx_done === 1'b1) done_cnt++;
    if (i_rst) begin
      mon_active = 1'b0;
      gap_ticks  = 0;
    end else if (!mon_active) begin
      if (o_tx_done === 1'b1) stray_done++;
      if (mon_prev && !o_tx) begin
        mon_active = 1'b1;
        mon_k = 0; mon_bad = 0; mon_slots = '0;
        gap_q.push_back(gap_ticks);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 0, 1);
          mon_exp = '0;
        end else mon_exp = exp_q.pop_front();
      end else if (i_tick) gap_ticks++;
    end else begin
      if (i_tick) begin
        mon_slot = mon_k / 16;
        if (mon_slot == 0)       mon_eb = 1'b0;
        else if (mon_slot <= NB) mon_eb = mon_exp[mon_slot-1];
        else                     mon_eb = 1'b1;
        if (mon_slot <= 9 && (mon_k % 16) == 8) mon_slots[mon_slot] = mon_prev;
        if (mon_prev !== mon_eb) mon_bad++;
        mon_k++;
      end
      if (o_tx_done === 1'b1 || mon_k > FRAME_TICKS) begin
        frames++;
        last_slots = mon_slots;
        last_byte  = mon_slots[8:1];
        chk("frame_data", mon_slots[8:1], mon_exp);
        chk("frame_bit_timing_errs", mon_bad, 0);
        chk("done_tick_position", mon_k, FRAME_TICKS);
        mon_active = 1'b0;
        gap_ticks  = 0;
      end
    end
    mon_prev = o_tx;
  end

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (frames < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("frame_timeout", frames >= n, 1);
  endtask

  typedef struct {
    logic [NB-1:0] data;
    logic [9:0]    slots;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int f0, p0, d0, bad, c, n, rdcnt, donek, ones;
    logic prev, started;
    logic lv[0:255];
    logic [NB-1:0] d32;

    // Line levels per bit slot, slot 0 = start, slot 9 = stop.
    tbl[0] = '{8'hA5, 10'b1101001010};
    tbl[1] = '{8'h00, 10'b1000000000};
    tbl[2] = '{8'hFF, 10'b1111111110};
    tbl[3] = '{8'h3C, 10'b1001111000};
    tbl[4] = '{8'h81, 10'b1100000010};

    i_rst = 1'b1; i_tick = 1'b0; empty32 = 1'b1; rdata32 = '0;
    fifo_refresh();
    repeat (4) @(negedge clk);
    chk("rst_tx", o_tx, 1);
    chk("rst_busy", o_tx_busy, 0);
    chk("rst_rd", o_fifo_rd, 0);
    chk("rst_done", o_tx_done, 0);
    i_rst = 1'b0;

    // Empty FIFO with ticks running: nothing moves.
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_fifo_rd !== 1'b0 || o_tx_busy !== 1'b0) bad++;
    end
    chk("idle_empty_bad_cycles", bad, 0);
    chk("idle_empty_pops", pops, 0);

    for (int i = 0; i < 5; i++) begin
      f0 = frames; p0 = pops; d0 = done_cnt;
      push(tbl[i].data);
      wait_frames(f0 + 1, 1000);
      repeat (3) @(negedge clk);
      chk("vec_slots", last_slots, tbl[i].slots);
      chk("vec_pops", pops - p0, 1);
      chk("vec_done_pulses", done_cnt - d0, 1);
      chk("vec_busy_after", o_tx_busy, 0);
      chk("vec_tx_after", o_tx, 1);
    end

    // Back-to-back frames from a pre-filled FIFO.
    f0 = frames; p0 = pops;
    gap_q.delete();
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_frames(f0 + 3, 3000);
    repeat (20) @(negedge clk);
    chk("btb_pops", pops - p0, 3);
    chk("btb_frames", frames - f0, 3);
    if (gap_q.size() >= 3) begin
      chk("btb_gap2_le1", gap_q[1] <= 1, 1);
      chk("btb_gap3_le1", gap_q[2] <= 1, 1);
    end else chk("btb_gap_count", gap_q.size(), 3);

    // Ticks withheld in the middle of the start bit.
    f0 = frames;
    push(8'h96);
    c = 0;
    while (!(mon_active && mon_k >= 5) && c < 500) begin @(negedge clk); c++; end
    chk("hold_reached_start", mon_active && mon_k >= 5 && mon_k < 16, 1);
    tick_en = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_tx !== 1'b0 || o_tx_busy !== 1'b1) bad++;
    end
    chk("hold_start_bad_cycles", bad, 0);
    tick_en = 1'b1;
    wait_frames(f0 + 1, 1000);

    // Reset in the middle of data bit 4 of 0x55.
    f0 = frames;
    push(8'h55);
    c = 0;
    while (!(mon_active && mon_k >= 16 * 5 + 4) && c < 1000) begin @(negedge clk); c++; end
    chk("rst_mid_reached", mon_active, 1);
    i_rst = 1'b1;
    #1;
    chk("rst_mid_tx", o_tx, 1);
    chk("rst_mid_busy", o_tx_busy, 0);
    chk("rst_mid_done", o_tx_done, 0);
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    chk("rst_mid_no_frame", frames - f0, 0);
    push(8'h81);
    wait_frames(f0 + 1, 1000);
    chk("rst_mid_next_byte", last_byte, 8'h81);

    // Randomized bursts with random tick spacing.
    for (int b = 0; b < 10; b++) begin
      f0 = frames;
      tick_div = $urandom_range(1, 4);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) push(NB'($urandom));
      wait_frames(f0 + n, n * 1000);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    tick_div = 3;
    repeat (10) @(negedge clk);
    chk("rand_exp_drained", exp_q.size(), 0);
    chk("stray_done", stray_done, 0);
    chk("rd_while_empty", rd_empty_viol, 0);

    // Two stop bits on the second instance: 0x80, done on the 176th frame tick.
    empty32 = 1'b0; rdata32 = 8'h80;
    n = 0; rdcnt = 0; donek = -1; started = 1'b0; prev = tx32;
    for (int k = 0; k < 256; k++) lv[k] = 1'bx;
    for (int cyc = 0; cyc < 2000 && donek < 0; cyc++) begin
      @(posedge clk); #1;
      if (rd32) begin rdcnt++; empty32 = 1'b1; end
      if (!started && prev && !tx32) started = 1'b1;
      else if (started && i_tick && n < 256) begin lv[n] = prev; n++; end
      if (done32) donek = n;
      prev = tx32;
    end
    for (int j = 0; j < NB; j++) d32[j] = lv[16 * (j + 1) + 8];
    ones = 0;
    for (int k = 144; k < 176; k++) if (lv[k] === 1'b1) ones++;
    repeat (5) @(negedge clk);
    chk("sb32_done_tick", donek, 176);
    chk("sb32_start_level", lv[8], 0);
    chk("sb32_data", d32, 8'h80);
    chk("sb32_stop_ticks_high", ones, 32);
    chk("sb32_pops", rdcnt, 1);
    chk("sb32_busy_after", busy32, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
